line_buffer_reader: RTL and testbench

//  Read sequencer directly downstream of the 100-entry 24-bit RGB line buffer.
//  On Start, it walks buffer addresses 0..LINE_LEN-1 and drives the buffer's read enable and address.
//  It captures the returned 8-bit R/G/B bytes (one-cycle registered read latency) into a 2-entry output FIFO.
//  It presents them as a 24-bit valid/ready pixel stream to the display output stage.
//  The top level multiplexes Addr with the writer's address.

---
 rtl/line_buffer_reader.sv | 134 +++++++++++++
 tb/tb_line_buffer_reader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_reader.sv
// Read sequencer for the RGB line buffer: walks addresses 0..LINE_LEN-1 and streams pixels out through a 2-entry FIFO.
// Optional horizontal 2x pixel doubling is enabled by defining PIXEL_DOUBLE_EN.
module line_buffer_reader #(
   parameter int LINE_LEN = 100,
   parameter int ADDR_W   = 7
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   output logic [ADDR_W-1:0] Addr,
   output logic              RE,
   input  logic [7:0]        BufR,
   input  logic [7:0]        BufG,
   input  logic [7:0]        BufB,
   output logic [23:0]       PixOut,
   output logic              PixValid,
   input  logic              PixReady,
   output logic              LineDone,
   output logic              Busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              rd_idx_q, rd_idx_d;
   logic              wr_idx_q, wr_idx_d;
   logic              linedone_q, linedone_d;
   logic [23:0]       fifo_q [2];

   logic              hs;
   logic              pop;
   logic              push;
   logic [2:0]        occ_after;

   assign hs   = PixValid & PixReady;
   assign push = inflight_q;

`ifdef PIXEL_DOUBLE_EN
   // Each head is shown twice; only the second handshake frees the entry.
   logic second_q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         second_q <= 1'b0;
      end else if (hs) begin
         second_q <= ~second_q;
      end
   end

   assign pop = hs & second_q;
`else
   assign pop = hs;
`endif

   // Credit rule: only issue a read if the result is guaranteed a FIFO slot.
   assign occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign RE        = (state_q == S_READ) && (occ_after < 3'd2);

   assign Addr     = rd_ptr_q;
   assign PixValid = (cnt_q != 2'd0);
   assign PixOut   = PixValid ? fifo_q[rd_idx_q] : 24'h0;
   assign LineDone = linedone_q;
   assign Busy     = (state_q != S_IDLE);

   always_comb begin
      state_d    = state_q;
      rd_ptr_d   = rd_ptr_q;
      inflight_d = RE;
      linedone_d = 1'b0;
      cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
      rd_idx_d   = rd_idx_q ^ pop;
      wr_idx_d   = wr_idx_q ^ push;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               state_d  = S_READ;
               rd_ptr_d = '0;
            end
         end
         S_READ: begin
            if (RE) begin
               if (rd_ptr_q == LAST_ADDR) begin
                  state_d = S_DRAIN;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            // Leave as the last pixel departs so LineDone lands in the first IDLE cycle.
            if (cnt_d == 2'd0) begin
               state_d    = S_IDLE;
               linedone_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= 2'd0;
         rd_idx_q   <= 1'b0;
         wr_idx_q   <= 1'b0;
         linedone_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         rd_idx_q   <= rd_idx_d;
         wr_idx_q   <= wr_idx_d;
         linedone_q <= linedone_d;
      end
   end

   // FIFO storage carries no reset; PixOut is gated by PixValid.
   always_ff @(posedge Clock) begin
      if (push) begin
         fifo_q[wr_idx_q] <= {BufR, BufG, BufB};
      end
   end

endmodule

// File: tb/tb_line_buffer_reader.sv
// Directed bench for line_buffer_reader: full lines, stalls, restart, mid-line reset, short lines, optional doubling.
module tb_line_buffer_reader;

`ifdef PIXEL_DOUBLE_EN
   localparam int MULT = 2;
`else
   localparam int MULT = 1;
`endif
   localparam int LEN = 100;
   localparam int NPIX = LEN * MULT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, ready;
   logic [6:0]  addr;
   logic        re, pv, ld, busy;
   logic [7:0]  br, bg, bb;
   logic [23:0] pix;

   logic        start4, ready4, re4, pv4, ld4, busy4;
   logic [1:0]  addr4;
   logic [7:0]  br4, bg4, bb4;
   logic [23:0] pix4;

   logic        start1, ready1, re1, pv1, ld1, busy1;
   logic [0:0]  addr1;
   logic [7:0]  br1, bg1, bb1;
   logic [23:0] pix1;

   line_buffer_reader #(.LINE_LEN(LEN), .ADDR_W(7)) dut (
      .Clock(clk), .Reset(rst), .Start(start), .Addr(addr), .RE(re),
      .BufR(br), .BufG(bg), .BufB(bb), .PixOut(pix), .PixValid(pv),
      .PixReady(ready), .LineDone(ld), .Busy(busy));

   line_buffer_reader #(.LINE_LEN(4), .ADDR_W(2)) dut4 (
      .Clock(clk), .Reset(rst), .Start(start4), .Addr(addr4), .RE(re4),
      .BufR(br4), .BufG(bg4), .BufB(bb4), .PixOut(pix4), .PixValid(pv4),
      .PixReady(ready4), .LineDone(ld4), .Busy(busy4));

   line_buffer_reader #(.LINE_LEN(1), .ADDR_W(1)) dut1 (
      .Clock(clk), .Reset(rst), .Start(start1), .Addr(addr1), .RE(re1),
      .BufR(br1), .BufG(bg1), .BufB(bb1), .PixOut(pix1), .PixValid(pv1),
      .PixReady(ready1), .LineDone(ld1), .Busy(busy1));

   function automatic logic [23:0] mem_fn(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {b, ~b, b ^ 8'h55};
   endfunction

   // Line buffer models with one-cycle registered read
   always @(posedge clk) if (re)  {br, bg, bb}    <= mem_fn(int'(addr));
   always @(posedge clk) if (re4) {br4, bg4, bb4} <= mem_fn(int'(addr4));
   always @(posedge clk) if (re1) {br1, bg1, bb1} <= mem_fn(int'(addr1));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Negedge monitor for the main instance
   int          npix = 0, re_cnt = 0, ld_cnt = 0, ld_cyc = 0;
   int          stab_viol = 0, credit_viol = 0, occ_viol = 0, bad_re = 0;
   int          occ = 0, occ_n;
   logic        par = 1'b0, hs_m, pop_m;
   logic        prev_stall = 1'b0, prev_rst = 1'b1;
   logic [23:0] prev_pix = '0;
   logic [23:0] pix_arr [0:2047];
   int          pix_cyc [0:2047];

   always @(negedge clk) begin
      hs_m  = pv && ready;
      pop_m = hs_m && (MULT == 1 || par);
      if (re) re_cnt++;
      if (re && !busy) bad_re++;
      if (re && (occ - (pop_m ? 1 : 0)) >= 2) credit_viol++;
      if (prev_stall && !prev_rst && (!pv || pix !== prev_pix)) stab_viol++;
      if (hs_m) begin
         if (npix < 2048) begin
            pix_arr[npix] = pix;
            pix_cyc[npix] = cyc;
         end
         npix++;
      end
      if (ld) begin
         ld_cnt++;
         ld_cyc = cyc;
      end
      occ_n = rst ? 0 : occ + (re ? 1 : 0) - (pop_m ? 1 : 0);
      if (occ_n > 2) occ_viol++;
      occ = occ_n;
      par = rst ? 1'b0 : (hs_m ? !par : par);
      prev_stall = pv && !ready;
      prev_pix = pix;
      prev_rst = rst;
   end

   int checks = 0;
   int errors = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; ready = 1'b1;
      start4 = 1'b0; ready4 = 1'b1; start1 = 1'b0; ready1 = 1'b1;
      step(); step();
      rst = 1'b0;
      checks++; if (addr !== 7'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", addr); end
      checks++; if (re !== 1'b0) begin errors++; $display("FAIL reset_re got %b exp 0", re); end
      checks++; if (pix !== 24'h0) begin errors++; $display("FAIL reset_pix got %h exp 0", pix); end
      checks++; if (pv !== 1'b0) begin errors++; $display("FAIL reset_pv got %b exp 0", pv); end
      checks++; if (ld !== 1'b0) begin errors++; $display("FAIL reset_ld got %b exp 0", ld); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      step();
   endtask

   task automatic test_line();
      int p0, r0, l0, sc, gaps;
      p0 = npix; r0 = re_cnt; l0 = ld_cnt;
      ready = 1'b1; start = 1'b1; sc = cyc;
      step();
      start = 1'b0;
      for (int k = 0; k < 600 && ld_cnt == l0; k++) step();
      repeat (4) step();
      checks++; if (ld_cnt - l0 !== 1) begin errors++; $display("FAIL line_ldcount got %0d exp 1", ld_cnt - l0); end
      checks++; if (npix - p0 !== NPIX) begin errors++; $display("FAIL line_npix got %0d exp %0d", npix - p0, NPIX); end
      checks++; if (re_cnt - r0 !== LEN) begin errors++; $display("FAIL line_re got %0d exp %0d", re_cnt - r0, LEN); end
      checks++; if (pix_cyc[p0] !== sc + 3) begin errors++; $display("FAIL line_first got %0d exp %0d", pix_cyc[p0] - sc, 3); end
      checks++; if (ld_cyc !== sc + NPIX + 3) begin errors++; $display("FAIL line_ldcyc got %0d exp %0d", ld_cyc - sc, NPIX + 3); end
      gaps = 0;
      for (int k = 1; k < NPIX; k++) if (pix_cyc[p0 + k] != pix_cyc[p0 + k - 1] + 1) gaps++;
      checks++; if (gaps !== 0) begin errors++; $display("FAIL line_gaps got %0d exp 0", gaps); end
      for (int k = 0; k < NPIX; k++) begin
         checks++;
         if (pix_arr[p0 + k] !== mem_fn(k / MULT)) begin
            errors++; $display("FAIL line_pix[%0d] got %h exp %h", k, pix_arr[p0 + k], mem_fn(k / MULT));
         end
      end
   endtask

   task automatic test_stall();
      int p0, r0, l0, s0, c0, o0, b0, stall, n;
      logic tog, stalled;
      p0 = npix; r0 = re_cnt; l0 = ld_cnt;
      s0 = stab_viol; c0 = credit_viol; o0 = occ_viol; b0 = bad_re;
      stall = 0; tog = 1'b0; stalled = 1'b0;
      ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 1500 && ld_cnt == l0; k++) begin
         n = npix - p0;
         if (stall > 0) begin
            ready = 1'b0; stall--;
         end else if (n == 50 && !stalled) begin
            stalled = 1'b1; stall = 4; ready = 1'b0;
         end else begin
            ready = tog; tog = !tog;
         end
         step();
      end
      ready = 1'b1;
      repeat (3) step();
      checks++; if (ld_cnt - l0 !== 1) begin errors++; $display("FAIL stall_ldcount got %0d exp 1", ld_cnt - l0); end
      checks++; if (npix - p0 !== NPIX) begin errors++; $display("FAIL stall_npix got %0d exp %0d", npix - p0, NPIX); end
      checks++; if (re_cnt - r0 !== LEN) begin errors++; $display("FAIL stall_re got %0d exp %0d", re_cnt - r0, LEN); end
      checks++; if (stab_viol - s0 !== 0) begin errors++; $display("FAIL stall_stable got %0d exp 0", stab_viol - s0); end
      checks++; if (credit_viol - c0 !== 0) begin errors++; $display("FAIL stall_credit got %0d exp 0", credit_viol - c0); end
      checks++; if (occ_viol - o0 !== 0) begin errors++; $display("FAIL stall_occ got %0d exp 0", occ_viol - o0); end
      checks++; if (bad_re - b0 !== 0) begin errors++; $display("FAIL stall_re_idle got %0d exp 0", bad_re - b0); end
      for (int k = 0; k < NPIX; k++) begin
         checks++;
         if (pix_arr[p0 + k] !== mem_fn(k / MULT)) begin
            errors++; $display("FAIL stall_pix[%0d] got %h exp %h", k, pix_arr[p0 + k], mem_fn(k / MULT));
         end
      end
   endtask

   task automatic test_restart();
      int p0, r0, l0, sc2;
      logic sent, seen;
      p0 = npix; r0 = re_cnt; l0 = ld_cnt;
      sent = 1'b0; seen = 1'b0; sc2 = 0;
      ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 600 && !seen; k++) begin
         if (ld) begin
            seen = 1'b1;
         end else begin
            start = (npix - p0 == 30) && !sent;
            if (start) sent = 1'b1;
            step();
         end
      end
      start = 1'b0;
      checks++; if (!seen) begin errors++; $display("FAIL restart_ld1 got 0 exp 1"); end
      checks++; if (re_cnt - r0 !== LEN) begin errors++; $display("FAIL restart_re1 got %0d exp %0d", re_cnt - r0, LEN); end
      checks++; if (npix - p0 !== NPIX) begin errors++; $display("FAIL restart_npix1 got %0d exp %0d", npix - p0, NPIX); end
      start = 1'b1; sc2 = cyc;
      step();
      start = 1'b0;
      checks++; if (re !== 1'b1 || addr !== 7'd0) begin errors++; $display("FAIL restart_addr got re=%b addr=%0d exp re=1 addr=0", re, addr); end
      for (int k = 0; k < 600 && ld_cnt - l0 < 2; k++) step();
      repeat (3) step();
      checks++; if (ld_cnt - l0 !== 2) begin errors++; $display("FAIL restart_ldcount got %0d exp 2", ld_cnt - l0); end
      checks++; if (ld_cyc !== sc2 + NPIX + 3) begin errors++; $display("FAIL restart_ldcyc got %0d exp %0d", ld_cyc - sc2, NPIX + 3); end
      checks++; if (npix - p0 !== 2 * NPIX) begin errors++; $display("FAIL restart_npix got %0d exp %0d", npix - p0, 2 * NPIX); end
      for (int k = 0; k < 2 * NPIX; k++) begin
         checks++;
         if (pix_arr[p0 + k] !== mem_fn((k % NPIX) / MULT)) begin
            errors++; $display("FAIL restart_pix[%0d] got %h exp %h", k, pix_arr[p0 + k], mem_fn((k % NPIX) / MULT));
         end
      end
   endtask

   task automatic test_reset_mid();
      int p0, p1, r1, l1;
      p0 = npix;
      ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 300 && npix - p0 < 40; k++) step();
      checks++; if (npix - p0 < 40) begin errors++; $display("FAIL rstmid_reach got %0d exp 40", npix - p0); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (addr !== 7'd0 || re !== 1'b0 || pix !== 24'h0 || pv !== 1'b0 || ld !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL rstmid_outs got addr=%0d re=%b pix=%h pv=%b ld=%b busy=%b exp all 0", addr, re, pix, pv, ld, busy);
      end
      l1 = ld_cnt;
      repeat (10) step();
      checks++; if (ld_cnt !== l1) begin errors++; $display("FAIL rstmid_noldone got %0d exp %0d", ld_cnt, l1); end
      p1 = npix; r1 = re_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (re !== 1'b1 || addr !== 7'd0) begin errors++; $display("FAIL rstmid_addr got re=%b addr=%0d exp re=1 addr=0", re, addr); end
      for (int k = 0; k < 600 && ld_cnt == l1; k++) step();
      repeat (3) step();
      checks++; if (ld_cnt - l1 !== 1) begin errors++; $display("FAIL rstmid_ldcount got %0d exp 1", ld_cnt - l1); end
      checks++; if (re_cnt - r1 !== LEN) begin errors++; $display("FAIL rstmid_re got %0d exp %0d", re_cnt - r1, LEN); end
      checks++; if (npix - p1 !== NPIX) begin errors++; $display("FAIL rstmid_npix got %0d exp %0d", npix - p1, NPIX); end
      for (int k = 0; k < NPIX; k++) begin
         checks++;
         if (pix_arr[p1 + k] !== mem_fn(k / MULT)) begin
            errors++; $display("FAIL rstmid_pix[%0d] got %h exp %h", k, pix_arr[p1 + k], mem_fn(k / MULT));
         end
      end
   endtask

   task automatic test_short();
      int na, np, ldc;
      na = 0; np = 0; ldc = 0;
      start4 = 1'b1;
      step();
      start4 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (re4) begin
            checks++;
            if (addr4 !== na[1:0] || na > 3) begin errors++; $display("FAIL short4_addr got %0d exp %0d", addr4, na); end
            na++;
         end
         if (pv4) begin
            checks++;
            if (pix4 !== mem_fn(np / MULT)) begin errors++; $display("FAIL short4_pix[%0d] got %h exp %h", np, pix4, mem_fn(np / MULT)); end
            np++;
         end
         if (ld4) ldc++;
         step();
      end
      checks++; if (na !== 4) begin errors++; $display("FAIL short4_re got %0d exp 4", na); end
      checks++; if (np !== 4 * MULT) begin errors++; $display("FAIL short4_npix got %0d exp %0d", np, 4 * MULT); end
      checks++; if (ldc !== 1 || busy4 !== 1'b0) begin errors++; $display("FAIL short4_done got ld=%0d busy=%b exp ld=1 busy=0", ldc, busy4); end
      na = 0; np = 0; ldc = 0;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (re1) begin
            checks++;
            if (addr1 !== 1'b0) begin errors++; $display("FAIL short1_addr got %0d exp 0", addr1); end
            na++;
         end
         if (pv1) begin
            checks++;
            if (pix1 !== mem_fn(0)) begin errors++; $display("FAIL short1_pix got %h exp %h", pix1, mem_fn(0)); end
            np++;
         end
         if (ld1) ldc++;
         step();
      end
      checks++; if (na !== 1) begin errors++; $display("FAIL short1_re got %0d exp 1", na); end
      checks++; if (np !== MULT) begin errors++; $display("FAIL short1_npix got %0d exp %0d", np, MULT); end
      checks++; if (ldc !== 1 || busy1 !== 1'b0) begin errors++; $display("FAIL short1_done got ld=%0d busy=%b exp ld=1 busy=0", ldc, busy1); end
   endtask

   initial begin
      test_reset();
      test_line();
      test_stall();
      test_restart();
      test_reset_mid();
      test_short();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
